// File: rtl/spi_arb_pkg.sv
// Purpose : shared types and constants for the SPI bus arbiter.
// Latency : n/a (types, constants and one constant function only).
// Backpr. : n/a.
package spi_arb_pkg;

  // Bus ownership phases: free, owned by one master, forced-idle gap between owners.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  // Pad levels while nobody owns the bus. The SCK idle level is a parameter of the arbiter.
  localparam logic SS_IDLE_O = 1'b1;  // slave selects are active-low: deselect all
  localparam logic SS_IDLE_T = 1'b0;  // keep driving the deselect
  localparam logic IO_IDLE_O = 1'b0;
  localparam logic IO_IDLE_T = 1'b1;  // data lines released
  localparam logic SCK_IDLE_T = 1'b0; // keep driving the idle clock level

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter.sv
// Purpose : round-robin arbiter sharing one SPI bus (SCK, SS, IO) between NUM_MASTERS masters.
// Latency : grant one edge after request; pads follow the owner combinationally; hand-over
//           takes GUARD_CYCLES+2 edges from the owner's req fall to the next grant.
// Backpr. : req/gnt handshake only; non-owners wait, no preemption.
// Ports   : clk/rst (sync, active-high); req/gnt/owner_id/busy arbitration; abort_err/err_clr
//           sticky abort status; m_* per-master tristate SPI (_o/_t in, _i out);
//           pad_* pad-bank side (_o/_t out, _i in).
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   NUM_MASTERS  = 2,
  parameter int   NUM_SS       = 1,
  parameter int   NUM_IO       = 2,
  parameter int   GUARD_CYCLES = 4,
  parameter logic SCK_IDLE     = 1'b0,
  localparam int  ID_W         = clog2_min1(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [ID_W-1:0]               owner_id,
  output logic                          busy,
  output logic                          abort_err,
  input  logic                          err_clr,
  input  logic [NUM_MASTERS-1:0]        m_sck_o,
  input  logic [NUM_MASTERS-1:0]        m_sck_t,
  output logic [NUM_MASTERS-1:0]        m_sck_i,
  input  logic [NUM_MASTERS*NUM_SS-1:0] m_ss_o,
  input  logic [NUM_MASTERS*NUM_SS-1:0] m_ss_t,
  output logic [NUM_MASTERS*NUM_SS-1:0] m_ss_i,
  input  logic [NUM_MASTERS*NUM_IO-1:0] m_io_o,
  input  logic [NUM_MASTERS*NUM_IO-1:0] m_io_t,
  output logic [NUM_MASTERS*NUM_IO-1:0] m_io_i,
  output logic                          pad_sck_o,
  output logic                          pad_sck_t,
  input  logic                          pad_sck_i,
  output logic [NUM_SS-1:0]             pad_ss_o,
  output logic [NUM_SS-1:0]             pad_ss_t,
  input  logic [NUM_SS-1:0]             pad_ss_i,
  output logic [NUM_IO-1:0]             pad_io_o,
  output logic [NUM_IO-1:0]             pad_io_t,
  input  logic [NUM_IO-1:0]             pad_io_i
);

  localparam int             CNT_W      = clog2_min1(GUARD_CYCLES + 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             abort_set;
  logic             owner_req;
  logic             owner_ss_low;

  // First requester at or after the pointer, wrapping. Scanning from the far end lets the
  // nearest hit overwrite earlier ones, so no early exit is needed.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                              input logic [ID_W-1:0]        p);
    logic [ID_W-1:0] w;
    int              idx;
    w = p;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NUM_MASTERS;
      if (r[idx]) w = ID_W'(idx);
    end
    return w;
  endfunction

  // Owner's request and whether it is actively driving any slave select low.
  always_comb begin
    owner_req    = 1'b0;
    owner_ss_low = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (owner_q == ID_W'(m)) begin
        owner_req = req[m];
        for (int s = 0; s < NUM_SS; s++) begin
          if (!m_ss_t[m*NUM_SS + s] && !m_ss_o[m*NUM_SS + s]) owner_ss_low = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    abort_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          owner_d = rr_pick(req, ptr_q);
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          // Releasing with a select still asserted means the transfer was cut short.
          abort_set = owner_ss_low;
          ptr_d     = (owner_q == ID_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
          if (GUARD_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LOAD;
          end
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new abort beats a simultaneous clear.
    err_d = abort_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Grant and status are pure decodes of registered state, so they change only on edges.
  always_comb begin
    busy      = (state_q == ST_GRANT);
    owner_id  = owner_q;
    abort_err = err_q;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      gnt[m] = busy && (owner_q == ID_W'(m));
    end
  end

  // Pad mux: owner's drive straight through, otherwise hold the bus in its idle state.
  always_comb begin
    pad_sck_o = SCK_IDLE;
    pad_sck_t = SCK_IDLE_T;
    pad_ss_o  = {NUM_SS{SS_IDLE_O}};
    pad_ss_t  = {NUM_SS{SS_IDLE_T}};
    pad_io_o  = {NUM_IO{IO_IDLE_O}};
    pad_io_t  = {NUM_IO{IO_IDLE_T}};
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (gnt[m]) begin
        pad_sck_o = m_sck_o[m];
        pad_sck_t = m_sck_t[m];
        pad_ss_o  = m_ss_o[m*NUM_SS +: NUM_SS];
        pad_ss_t  = m_ss_t[m*NUM_SS +: NUM_SS];
        pad_io_o  = m_io_o[m*NUM_IO +: NUM_IO];
        pad_io_t  = m_io_t[m*NUM_IO +: NUM_IO];
      end
    end
  end

  // Readback: only the owner sees the real pins; others see a quiet, deselected bus.
  always_comb begin
    m_sck_i = '0;
    m_ss_i  = '1;
    m_io_i  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      m_sck_i[m]                  = gnt[m] ? pad_sck_i : SCK_IDLE;
      m_ss_i[m*NUM_SS +: NUM_SS]  = gnt[m] ? pad_ss_i  : {NUM_SS{1'b1}};
      m_io_i[m*NUM_IO +: NUM_IO]  = gnt[m] ? pad_io_i  : {NUM_IO{1'b0}};
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Purpose : self-checking bench for spi_bus_arbiter, two configurations side by side.
// Latency : n/a.
// Backpr. : n/a.
module tb_spi_bus_arbiter;

  localparam int AM = 2, ASS = 1, AIO = 2, AG = 4;
  localparam int BM = 4, BSS = 2, BIO = 4, BG = 0;
  localparam bit [1:0] SCKI = 2'b10;  // idle SCK level: instance 0 -> 0, instance 1 -> 1

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Generic stimulus views, sized for the larger instance.
  logic [3:0]  v_req     [2];
  logic [3:0]  v_sck_o   [2];
  logic [3:0]  v_sck_t   [2];
  logic [7:0]  v_ss_o    [2];
  logic [7:0]  v_ss_t    [2];
  logic [15:0] v_io_o    [2];
  logic [15:0] v_io_t    [2];
  logic        v_pad_sck_i [2];
  logic [1:0]  v_pad_ss_i  [2];
  logic [3:0]  v_pad_io_i  [2];
  logic        v_err_clr [2];

  // Generic observation views.
  logic [3:0]  o_gnt [2];
  int          o_owner [2];
  logic        o_busy [2], o_err [2];
  logic        o_pad_sck_o [2], o_pad_sck_t [2];
  logic [1:0]  o_pad_ss_o [2], o_pad_ss_t [2];
  logic [3:0]  o_pad_io_o [2], o_pad_io_t [2];
  logic [3:0]  o_m_sck_i [2];
  logic [7:0]  o_m_ss_i [2];
  logic [15:0] o_m_io_i [2];

  // Instance A: 2 masters, 1 SS, 2 IO, guard 4, SCK idles low.
  logic [AM-1:0] a_gnt, a_m_sck_i;
  logic [0:0] a_owner_id;
  logic a_busy, a_abort_err, a_pad_sck_o, a_pad_sck_t;
  logic [AM*ASS-1:0] a_m_ss_i;
  logic [AM*AIO-1:0] a_m_io_i;
  logic [ASS-1:0] a_pad_ss_o, a_pad_ss_t;
  logic [AIO-1:0] a_pad_io_o, a_pad_io_t;

  spi_bus_arbiter #(.NUM_MASTERS(AM), .NUM_SS(ASS), .NUM_IO(AIO), .GUARD_CYCLES(AG),
                    .SCK_IDLE(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .req(v_req[0][AM-1:0]), .gnt(a_gnt), .owner_id(a_owner_id),
    .busy(a_busy), .abort_err(a_abort_err), .err_clr(v_err_clr[0]),
    .m_sck_o(v_sck_o[0][AM-1:0]), .m_sck_t(v_sck_t[0][AM-1:0]), .m_sck_i(a_m_sck_i),
    .m_ss_o(v_ss_o[0][AM*ASS-1:0]), .m_ss_t(v_ss_t[0][AM*ASS-1:0]), .m_ss_i(a_m_ss_i),
    .m_io_o(v_io_o[0][AM*AIO-1:0]), .m_io_t(v_io_t[0][AM*AIO-1:0]), .m_io_i(a_m_io_i),
    .pad_sck_o(a_pad_sck_o), .pad_sck_t(a_pad_sck_t), .pad_sck_i(v_pad_sck_i[0]),
    .pad_ss_o(a_pad_ss_o), .pad_ss_t(a_pad_ss_t), .pad_ss_i(v_pad_ss_i[0][ASS-1:0]),
    .pad_io_o(a_pad_io_o), .pad_io_t(a_pad_io_t), .pad_io_i(v_pad_io_i[0][AIO-1:0])
  );

  // Instance B: 4 masters, 2 SS, 4 IO, no guard gap, SCK idles high.
  logic [BM-1:0] b_gnt, b_m_sck_i;
  logic [1:0] b_owner_id;
  logic b_busy, b_abort_err, b_pad_sck_o, b_pad_sck_t;
  logic [BM*BSS-1:0] b_m_ss_i;
  logic [BM*BIO-1:0] b_m_io_i;
  logic [BSS-1:0] b_pad_ss_o, b_pad_ss_t;
  logic [BIO-1:0] b_pad_io_o, b_pad_io_t;

  spi_bus_arbiter #(.NUM_MASTERS(BM), .NUM_SS(BSS), .NUM_IO(BIO), .GUARD_CYCLES(BG),
                    .SCK_IDLE(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .req(v_req[1]), .gnt(b_gnt), .owner_id(b_owner_id),
    .busy(b_busy), .abort_err(b_abort_err), .err_clr(v_err_clr[1]),
    .m_sck_o(v_sck_o[1]), .m_sck_t(v_sck_t[1]), .m_sck_i(b_m_sck_i),
    .m_ss_o(v_ss_o[1]), .m_ss_t(v_ss_t[1]), .m_ss_i(b_m_ss_i),
    .m_io_o(v_io_o[1]), .m_io_t(v_io_t[1]), .m_io_i(b_m_io_i),
    .pad_sck_o(b_pad_sck_o), .pad_sck_t(b_pad_sck_t), .pad_sck_i(v_pad_sck_i[1]),
    .pad_ss_o(b_pad_ss_o), .pad_ss_t(b_pad_ss_t), .pad_ss_i(v_pad_ss_i[1]),
    .pad_io_o(b_pad_io_o), .pad_io_t(b_pad_io_t), .pad_io_i(v_pad_io_i[1])
  );

  assign o_gnt[0] = 4'(a_gnt);              assign o_gnt[1] = b_gnt;
  assign o_owner[0] = int'(a_owner_id);     assign o_owner[1] = int'(b_owner_id);
  assign o_busy[0] = a_busy;                assign o_busy[1] = b_busy;
  assign o_err[0] = a_abort_err;            assign o_err[1] = b_abort_err;
  assign o_pad_sck_o[0] = a_pad_sck_o;      assign o_pad_sck_o[1] = b_pad_sck_o;
  assign o_pad_sck_t[0] = a_pad_sck_t;      assign o_pad_sck_t[1] = b_pad_sck_t;
  assign o_pad_ss_o[0] = 2'(a_pad_ss_o);    assign o_pad_ss_o[1] = b_pad_ss_o;
  assign o_pad_ss_t[0] = 2'(a_pad_ss_t);    assign o_pad_ss_t[1] = b_pad_ss_t;
  assign o_pad_io_o[0] = 4'(a_pad_io_o);    assign o_pad_io_o[1] = b_pad_io_o;
  assign o_pad_io_t[0] = 4'(a_pad_io_t);    assign o_pad_io_t[1] = b_pad_io_t;
  assign o_m_sck_i[0] = 4'(a_m_sck_i);      assign o_m_sck_i[1] = b_m_sck_i;
  assign o_m_ss_i[0] = 8'(a_m_ss_i);        assign o_m_ss_i[1] = b_m_ss_i;
  assign o_m_io_i[0] = 16'(a_m_io_i);       assign o_m_io_i[1] = b_m_io_i;

  function automatic int nm(input int k);  return (k == 0) ? AM  : BM;  endfunction
  function automatic int nss(input int k); return (k == 0) ? ASS : BSS; endfunction
  function automatic int nio(input int k); return (k == 0) ? AIO : BIO; endfunction
  function automatic int gc(input int k);  return (k == 0) ? AG  : BG;  endfunction

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), how many more edges the bus must stay
  // free before anyone can win it, where the round-robin search starts, sticky error.
  int md_own [2];
  int md_cool [2];
  int md_ptr [2];
  bit md_err [2];

  function automatic bit ss_low(input int k, input int m);
    bit low = 0;
    for (int s = 0; s < nss(k); s++)
      if (!v_ss_t[k][m*nss(k)+s] && !v_ss_o[k][m*nss(k)+s]) low = 1;
    return low;
  endfunction

  task automatic model_update(input int k);
    bit set_abort;
    int cand;
    set_abort = 0;
    if (rst) begin
      md_own[k] = -1; md_cool[k] = 0; md_ptr[k] = 0; md_err[k] = 0;
    end else begin
      if (md_own[k] >= 0) begin
        if (!v_req[k][md_own[k]]) begin
          set_abort  = ss_low(k, md_own[k]);
          md_ptr[k]  = (md_own[k] + 1) % nm(k);
          md_own[k]  = -1;
          md_cool[k] = gc(k);
        end
      end else if (md_cool[k] > 0) begin
        md_cool[k]--;
      end else begin
        for (int i = 0; i < nm(k); i++) begin
          cand = (md_ptr[k] + i) % nm(k);
          if (md_own[k] < 0 && v_req[k][cand]) md_own[k] = cand;
        end
      end
      md_err[k] = set_abort ? 1'b1 : (v_err_clr[k] ? 1'b0 : md_err[k]);
    end
  endtask

  task automatic check_all(input int k);
    int own;
    logic [31:0] e_gnt, e_sck_o, e_sck_t, e_ss_o, e_ss_t, e_io_o, e_io_t, e_sck_i, e_ss_i, e_io_i;
    own = md_own[k];
    e_gnt = 0; e_sck_o = 0; e_sck_t = 0; e_ss_o = 0; e_ss_t = 0; e_io_o = 0; e_io_t = 0;
    e_sck_i = 0; e_ss_i = 0; e_io_i = 0;
    if (own >= 0) begin
      e_gnt[own] = 1'b1;
      e_sck_o[0] = v_sck_o[k][own];
      e_sck_t[0] = v_sck_t[k][own];
      for (int s = 0; s < nss(k); s++) begin
        e_ss_o[s] = v_ss_o[k][own*nss(k)+s];
        e_ss_t[s] = v_ss_t[k][own*nss(k)+s];
      end
      for (int b = 0; b < nio(k); b++) begin
        e_io_o[b] = v_io_o[k][own*nio(k)+b];
        e_io_t[b] = v_io_t[k][own*nio(k)+b];
      end
      check_eq($sformatf("owner_id%0d", k), o_owner[k], own);
    end else begin
      e_sck_o[0] = SCKI[k];
      for (int s = 0; s < nss(k); s++) e_ss_o[s] = 1'b1;
      for (int b = 0; b < nio(k); b++) e_io_t[b] = 1'b1;
    end
    for (int m = 0; m < nm(k); m++) begin
      e_sck_i[m] = (m == own) ? v_pad_sck_i[k] : SCKI[k];
      for (int s = 0; s < nss(k); s++) e_ss_i[m*nss(k)+s] = (m == own) ? v_pad_ss_i[k][s] : 1'b1;
      for (int b = 0; b < nio(k); b++) e_io_i[m*nio(k)+b] = (m == own) ? v_pad_io_i[k][b] : 1'b0;
    end
    check_eq($sformatf("gnt%0d", k), o_gnt[k], e_gnt);
    check_eq($sformatf("busy%0d", k), o_busy[k], (own >= 0));
    check_eq($sformatf("abort_err%0d", k), o_err[k], md_err[k]);
    check_eq($sformatf("pad_sck_o%0d", k), o_pad_sck_o[k], e_sck_o);
    check_eq($sformatf("pad_sck_t%0d", k), o_pad_sck_t[k], e_sck_t);
    check_eq($sformatf("pad_ss_o%0d", k), o_pad_ss_o[k], e_ss_o);
    check_eq($sformatf("pad_ss_t%0d", k), o_pad_ss_t[k], e_ss_t);
    check_eq($sformatf("pad_io_o%0d", k), o_pad_io_o[k], e_io_o);
    check_eq($sformatf("pad_io_t%0d", k), o_pad_io_t[k], e_io_t);
    check_eq($sformatf("m_sck_i%0d", k), o_m_sck_i[k], e_sck_i);
    check_eq($sformatf("m_ss_i%0d", k), o_m_ss_i[k], e_ss_i);
    check_eq($sformatf("m_io_i%0d", k), o_m_io_i[k], e_io_i);
  endtask

  // One clock: model follows the edge, outputs are compared mid-cycle.
  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic rand_data(input int k);
    v_sck_o[k]     = 4'($urandom);
    v_sck_t[k]     = 4'($urandom);
    v_io_o[k]      = 16'($urandom);
    v_io_t[k]      = 16'($urandom);
    v_pad_sck_i[k] = 1'($urandom);
    v_pad_ss_i[k]  = 2'($urandom);
    v_pad_io_i[k]  = 4'($urandom);
  endtask

  task automatic quiet_selects(input int k);
    v_ss_o[k]    = 8'hFF;
    v_ss_t[k]    = 8'h00;
    v_err_clr[k] = 1'b0;
  endtask

  task automatic rand_inputs(input int k);
    rand_data(k);
    for (int m = 0; m < nm(k); m++)
      v_req[k][m] = (md_own[k] == m) ? ($urandom_range(7) != 0) : ($urandom_range(1) == 1);
    v_ss_o[k]    = 8'($urandom | $urandom);
    v_ss_t[k]    = 8'($urandom & $urandom);
    v_err_clr[k] = ($urandom_range(7) == 0);
  endtask

  initial begin
    int n;
    bit done;
    int held;
    logic [3:0] prev;
    int order[$];

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      md_own[k] = -1; md_cool[k] = 0; md_ptr[k] = 0; md_err[k] = 0;
      v_req[k] = '0;
      rand_data(k);
      quiet_selects(k);
    end
    step();
    step();
    check_eq("rst_owner_id", o_owner[0], 0);
    check_eq("rst_pad_ss", o_pad_ss_o[0], 1);
    check_eq("rst_sck_idle_b", o_pad_sck_o[1], 1);
    rst = 1'b0;

    // Single request: grant one edge later, non-owner sees a quiet bus.
    v_req[0] = 4'b0001;
    step();
    check_eq("t1_gnt", o_gnt[0], 4'b0001);
    check_eq("t1_m1_sck_i", o_m_sck_i[0][1], 0);
    check_eq("t1_m1_ss_i", o_m_ss_i[0][1], 1);

    // Simultaneous requests from a fresh pointer, then hand-over through the guard gap.
    rst = 1'b1; v_req[0] = '0; step(); rst = 1'b0;
    v_req[0] = 4'b0011;
    step();
    check_eq("t2_first_gnt", o_gnt[0], 4'b0001);
    step();
    v_req[0] = 4'b0010;
    n = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step(); n++;
      if (o_gnt[0] == 4'b0010) done = 1;
    end
    check_eq("t2_handover_edges", n, AG + 2);

    // Owner drops req with its select still low: sticky abort, then cleared.
    v_ss_o[0] = 8'h00; v_ss_t[0] = 8'h00;
    step();
    v_req[0] = '0;
    step();
    check_eq("t3_abort_set", o_err[0], 1);
    check_eq("t3_pad_ss_idle", o_pad_ss_o[0], 1);
    quiet_selects(0);
    v_err_clr[0] = 1'b1;
    step();
    check_eq("t3_abort_clr", o_err[0], 0);
    v_err_clr[0] = 1'b0;

    // Reset while m1 owns mid-transfer with a select asserted.
    v_req[0] = 4'b0010;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (o_gnt[0] == 4'b0010) done = 1;
    end
    check_eq("t5_m1_owns", o_gnt[0], 4'b0010);
    v_ss_o[0] = 8'h00;
    step(); step();
    rst = 1'b1;
    step();
    check_eq("t5_gnt", o_gnt[0], 0);
    check_eq("t5_busy", o_busy[0], 0);
    check_eq("t5_err", o_err[0], 0);
    check_eq("t5_pad_io_t", o_pad_io_t[0], 4'b0011);
    rst = 1'b0; v_req[0] = '0; quiet_selects(0);

    // Four masters all requesting, each releases after 8 cycles: strict rotation.
    v_req[1] = 4'hF; prev = '0; held = 0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      step();
      if (o_gnt[1] != 0 && o_gnt[1] != prev) begin
        order.push_back(o_owner[1]);
        held = 0;
      end
      prev = o_gnt[1];
      v_req[1] = 4'hF;
      if (o_gnt[1] != 0) begin
        held++;
        if (held >= 8) v_req[1][o_owner[1]] = 1'b0;
      end
    end
    check_eq("t4_grants", order.size(), 5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("t4_order%0d", i), (i < order.size()) ? order[i] : -1, i % 4);

    // No guard gap: one idle edge then the next master.
    v_req[1] = 4'b1110;
    n = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step(); n++;
      if (o_gnt[1] != 0) done = 1;
    end
    check_eq("t6_handover_edges", n, BG + 2);
    check_eq("t6_owner", o_owner[1], 1);
    v_pad_io_i[1] = 4'hA;
    step();
    check_eq("t6_owner_io_i", o_m_io_i[1][7:4], 4'hA);
    check_eq("t6_other_io_i", o_m_io_i[1][3:0], 4'h0);

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(299) == 0);
      rand_inputs(0);
      rand_inputs(1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
